// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, bit-timer width
// and the transmitter state encoding.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam logic [TICK_W-1:0] TICK_LAST =
    TICK_W'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter; o_tick marks the last sample
// of a line bit. Held at zero while disabled.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  logic [TICK_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == TICK_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: THR/TSR double buffer, start, data LSB
// first, parity and stop bits, 16 clocks per line bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 mclkx16,
  input  logic                 reset,
  input  logic                 write,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 paritymode,
  output logic                 tx,
  output logic                 tbre,
  output logic                 tsre
);

  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            r_state;
  logic                 r_write_d;
  logic [DATA_BITS-1:0] r_thr;
  logic [DATA_BITS-1:0] r_tsr;
  logic                 r_par;
  logic [2:0]           r_bitidx;
  logic                 r_stopidx;

  logic w_tick;
  logic w_en;
  logic w_wr_rise;
  logic w_last_stop;
  logic w_load;

  assign w_en      = (r_state != TX_IDLE);
  assign w_wr_rise = write && !r_write_d && tbre;

  assign w_last_stop = (r_state == TX_STOP) && w_tick &&
                       (r_stopidx == STOP_LAST);

  // Reload straight out of the last stop bit keeps frames gapless
  assign w_load = !tbre &&
                  ((r_state == TX_IDLE) || w_last_stop);

  uart_bit_timer u_timer (
    .i_clk   (mclkx16),
    .i_rst_n (reset),
    .i_en    (w_en),
    .o_tick  (w_tick)
  );

  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) begin
      r_write_d <= 1'b0;
      r_thr     <= '0;
      tbre      <= 1'b1;
    end else begin
      r_write_d <= write;
      if (w_load) begin
        tbre <= 1'b1;
      end else if (w_wr_rise) begin
        r_thr <= wdata;
        tbre  <= 1'b0;
      end
    end
  end

  always_ff @(posedge mclkx16 or negedge reset) begin
    if (!reset) begin
      r_state   <= TX_IDLE;
      r_tsr     <= '0;
      r_par     <= 1'b0;
      r_bitidx  <= '0;
      r_stopidx <= 1'b0;
      tx        <= 1'b1;
      tsre      <= 1'b1;
    end else if (w_load) begin
      r_tsr   <= r_thr;
      r_par   <= paritymode ^ (^r_thr);
      tsre    <= 1'b0;
      tx      <= 1'b0;
      r_state <= TX_START;
    end else begin
      unique case (r_state)
        TX_IDLE: begin
          tx <= 1'b1;
        end
        TX_START: begin
          if (w_tick) begin
            tx       <= r_tsr[0];
            r_bitidx <= '0;
            r_state  <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            if (r_bitidx == BIT_LAST) begin
              tx      <= r_par;
              r_state <= TX_PARITY;
            end else begin
              r_tsr    <= r_tsr >> 1;
              tx       <= r_tsr[1];
              r_bitidx <= r_bitidx + 3'd1;
            end
          end
        end
        TX_PARITY: begin
          if (w_tick) begin
            tx        <= 1'b1;
            r_stopidx <= 1'b0;
            r_state   <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (w_tick) begin
            if (r_stopidx == STOP_LAST) begin
              tsre    <= 1'b1;
              r_state <= TX_IDLE;
            end else begin
              r_stopidx <= r_stopidx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a line decoder pops expected
// bytes/parity pushed by the stimulus side.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       write;
  logic [7:0] wdata;
  logic       pm;
  logic       tx;
  logic       tbre;
  logic       tsre;

  typedef struct {
    logic [7:0] d;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   starts[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   fails  = 0;
  int   frames = 0;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .mclkx16    (clk),
    .reset      (rst_n),
    .write      (write),
    .wdata      (wdata),
    .paritymode (pm),
    .tx         (tx),
    .tbre       (tbre),
    .tsre       (tsre)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d,
                              input logic m);
    exp_t e;
    e.d = d;
    e.p = logic'(($countones(d) + int'(m)) % 2);
    return e;
  endfunction

  // Line decoder: samples each bit at its middle
  initial begin : monitor
    logic        prev;
    logic [10:0] smp;
    bit          ab;
    int          sc;
    exp_t        e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b1;
      end else begin
        if (prev && !tx) begin
          sc  = cyc;
          ab  = 0;
          smp = '0;
          for (int b = 0; b < 11; b++) begin
            for (int w = 0; w < (b == 0 ? 7 : 16); w++) begin
              @(negedge clk);
              if (!rst_n) ab = 1;
            end
            if (ab) break;
            smp[b] = tx;
          end
          if (!ab) begin
            frames++;
            starts.push_back(sc);
            if (q.size() == 0) begin
              chk("unexpected_frame", 32'(smp), 32'h0);
            end else begin
              e = q.pop_front();
              chk("start_bit", 32'(smp[0]), 32'h0);
              chk("data", 32'(smp[8:1]), 32'(e.d));
              chk("parity", 32'(smp[9]), 32'(e.p));
              chk("stop_bit", 32'(smp[10]), 32'h1);
            end
          end
        end
        prev = tx;
      end
    end
  end

  task automatic do_write(input logic [7:0] d,
                          input logic m,
                          output int wc);
    @(negedge clk);
    wdata = d;
    pm    = m;
    write = 1'b1;
    wc    = cyc;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_tbre();
    int n = 0;
    while (!tbre && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!tbre) chk("tbre_timeout", 32'(tbre), 32'h1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(tsre && q.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 32'(q.size()), 32'h0);
    repeat (4) @(negedge clk);
  endtask

  initial begin : stim
    int   wc;
    int   fc;
    logic m;
    rst_n = 1'b0;
    write = 1'b0;
    wdata = '0;
    pm    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'h1);
    chk("rst_tbre", 32'(tbre), 32'h1);
    chk("rst_tsre", 32'(tsre), 32'h1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0x55 odd parity with exact edge timing
    q.push_back(mk(8'h55, 1'b1));
    do_write(8'h55, 1'b1, wc);
    chk("t1_pre_tx", 32'(tx), 32'h1);
    chk("t1_tbre_full", 32'(tbre), 32'h0);
    wait_cyc(wc + 2);
    chk("t1_start_tx", 32'(tx), 32'h0);
    chk("t1_tsre_busy", 32'(tsre), 32'h0);
    chk("t1_tbre_free", 32'(tbre), 32'h1);
    wait_cyc(wc + 177);
    chk("t1_tsre_late", 32'(tsre), 32'h0);
    wait_cyc(wc + 178);
    chk("t1_tsre_done", 32'(tsre), 32'h1);
    wait_idle();

    // 0xA7 even parity
    q.push_back(mk(8'hA7, 1'b0));
    do_write(8'hA7, 1'b0, wc);
    wait_idle();

    // Back-to-back frames with no gap
    starts.delete();
    q.push_back(mk(8'h01, 1'b0));
    do_write(8'h01, 1'b0, wc);
    wait_tbre();
    q.push_back(mk(8'h80, 1'b0));
    do_write(8'h80, 1'b0, fc);
    wait_cyc(wc + 2 + 176);
    chk("t3_tsre_mid", 32'(tsre), 32'h0);
    wait_cyc(wc + 2 + 351);
    chk("t3_tsre_late", 32'(tsre), 32'h0);
    wait_cyc(wc + 2 + 352);
    chk("t3_tsre_done", 32'(tsre), 32'h1);
    wait_idle();
    if (starts.size() == 2)
      chk("t3_gap", 32'(starts[1] - starts[0]), 32'd176);
    else
      chk("t3_nframes", 32'(starts.size()), 32'd2);

    // Third write while THR full is dropped
    fc = frames;
    q.push_back(mk(8'h11, 1'b1));
    do_write(8'h11, 1'b1, wc);
    q.push_back(mk(8'h22, 1'b1));
    do_write(8'h22, 1'b1, wc);
    chk("t4_tbre_full", 32'(tbre), 32'h0);
    do_write(8'h33, 1'b1, wc);
    wait_idle();
    repeat (200) @(negedge clk);
    chk("t4_frames", 32'(frames - fc), 32'd2);

    // Reset in the middle of a frame
    q.push_back(mk(8'hF0, 1'b0));
    do_write(8'hF0, 1'b0, wc);
    wait_cyc(wc + 2 + 16 * 4 + 3);
    fc = frames;
    rst_n = 1'b0;
    #1;
    chk("t5_tx_async", 32'(tx), 32'h1);
    chk("t5_tbre_async", 32'(tbre), 32'h1);
    chk("t5_tsre_async", 32'(tsre), 32'h1);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("t5_no_residual", 32'(frames - fc), 32'd0);
    chk("t5_tsre_idle", 32'(tsre), 32'h1);
    q.push_back(mk(8'h3C, 1'b1));
    do_write(8'h3C, 1'b1, wc);
    wait_idle();

    // Write held high is a single write
    fc = frames;
    @(negedge clk);
    wdata = 8'h0F;
    pm    = 1'b0;
    write = 1'b1;
    q.push_back(mk(8'h0F, 1'b0));
    repeat (100) @(negedge clk);
    write = 1'b0;
    wait_idle();
    repeat (200) @(negedge clk);
    chk("t6_frames", 32'(frames - fc), 32'd1);

    // Isolated random frames, parity mode flipped mid-frame
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      m     = logic'($urandom_range(1));
      wdata = 8'($urandom);
      q.push_back(mk(wdata, m));
      do_write(wdata, m, wc);
      repeat (2) @(negedge clk);
      pm = logic'($urandom_range(1));
    end
    wait_idle();

    // Streaming random frames gated only by tbre
    m  = logic'($urandom_range(1));
    pm = m;
    for (int i = 0; i < 10; i++) begin
      wait_tbre();
      repeat ($urandom_range(20)) @(negedge clk);
      wdata = 8'($urandom);
      q.push_back(mk(wdata, m));
      do_write(wdata, m, wc);
    end
    wait_idle();
    repeat (200) @(negedge clk);

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
